// File: rtl/register_file.sv
// Multi-entry register file: two combinational read ports, one write port with
// load/inc/dec/clear modes, optional write-through bypass and hardwired-zero reg 0.
module register_file #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    ZERO_REG    = 0,
  parameter int                    BYPASS      = 1,
  localparam int                   AW          = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we_n,
  input  logic [1:0]            i_wmode,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr_a,
  output logic [DATA_WIDTH-1:0] o_rdata_a,
  input  logic [AW-1:0]         i_raddr_b,
  output logic [DATA_WIDTH-1:0] o_rdata_b
);

  localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_waddr_ok;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_nxt;

  // Address 0 is only a dead target when the zero register is enabled.
  assign w_waddr_ok = ({1'b0, i_waddr} < NREGS) &&
                      !((ZERO_REG != 0) && (i_waddr == '0));
  assign w_wr_en    = !i_we_n && !i_reset && w_waddr_ok;

  always_comb begin
    w_old = '0;
    if ({1'b0, i_waddr} < NREGS) w_old = r_regs[i_waddr];
  end

  always_comb begin
    w_nxt = '0;
    case (i_wmode)
      2'b00:   w_nxt = i_wdata;
      2'b01:   w_nxt = w_old + DATA_WIDTH'(1);
      2'b10:   w_nxt = w_old - DATA_WIDTH'(1);
      default: w_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= w_nxt;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (({1'b0, addr} < NREGS) && !((ZERO_REG != 0) && (addr == '0))) begin
      if ((BYPASS != 0) && w_wr_en && (addr == i_waddr)) val = w_nxt;
      else                                               val = r_regs[addr];
    end
    return val;
  endfunction

  always_comb begin
    o_rdata_a = read_port(i_raddr_a);
    o_rdata_b = read_port(i_raddr_b);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: two instances (zero-reg/bypass/6 regs and
// plain/no-bypass/8 regs) checked against a behavioural model via a scoreboard queue.
module tb_register_file;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       we_n = 1'b1;
  logic [1:0] wmode = 2'b00;
  logic [2:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [2:0] raddr_a = '0;
  logic [2:0] raddr_b = '0;
  logic [7:0] rda0, rdb0, rda1, rdb1;

  always #5 clk = ~clk;

  // Instance 0: 6 registers, reg 0 hardwired to zero, bypass on.
  register_file #(
    .DATA_WIDTH(8), .NUM_REGS(6), .RESET_VALUE(8'h5A), .ZERO_REG(1), .BYPASS(1)
  ) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_we_n(we_n), .i_wmode(wmode),
    .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr_a(raddr_a), .o_rdata_a(rda0),
    .i_raddr_b(raddr_b), .o_rdata_b(rdb0)
  );

  // Instance 1: 8 registers, no zero register, bypass off.
  register_file #(
    .DATA_WIDTH(8), .NUM_REGS(8), .RESET_VALUE(8'h5A), .ZERO_REG(0), .BYPASS(0)
  ) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_we_n(we_n), .i_wmode(wmode),
    .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr_a(raddr_a), .o_rdata_a(rda1),
    .i_raddr_b(raddr_b), .o_rdata_b(rdb1)
  );

  logic [7:0] m0 [8];
  logic [7:0] m1 [8];
  logic [7:0] exp_q [$];
  string      tag_q [$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  function automatic logic [7:0] nxt_of(input logic [7:0] old, input logic [1:0] mode,
                                        input logic [7:0] d);
    case (mode)
      2'b00:   return d;
      2'b01:   return old + 8'd1;
      2'b10:   return old - 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic qual0();
    return !reset && !we_n && (waddr < 3'd6) && (waddr != 3'd0);
  endfunction

  function automatic logic [7:0] exp0(input logic [2:0] a);
    if (a == 3'd0 || a >= 3'd6) return 8'h00;
    if (qual0() && a == waddr) return nxt_of(m0[a], wmode, wdata);
    return m0[a];
  endfunction

  function automatic logic [7:0] exp1(input logic [2:0] a);
    return m1[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m0[i] = 8'h5A;
      m1[i] = 8'h5A;
    end
  endtask

  task automatic drive(input logic wn, input logic [1:0] md, input logic [2:0] wa,
                       input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    we_n = wn; wmode = md; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
  endtask

  task automatic check(input string tag);
    logic [7:0] obs [4];
    logic [7:0] e;
    string      t;
    exp_q.push_back(exp0(raddr_a)); tag_q.push_back({tag, "/u0.a"});
    exp_q.push_back(exp0(raddr_b)); tag_q.push_back({tag, "/u0.b"});
    exp_q.push_back(exp1(raddr_a)); tag_q.push_back({tag, "/u1.a"});
    exp_q.push_back(exp1(raddr_b)); tag_q.push_back({tag, "/u1.b"});
    #1;
    obs[0] = rda0; obs[1] = rdb0; obs[2] = rda1; obs[3] = rdb1;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (obs[k] === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, obs[k], e);
      end
    end
  endtask

  // One rising edge; the model commits the write exactly when the DUT should.
  task automatic tick();
    logic [7:0] n;
    @(posedge clk);
    if (!reset && !we_n) begin
      n = nxt_of(m0[waddr], wmode, wdata);
      if (qual0()) m0[waddr] = n;
      m1[waddr] = nxt_of(m1[waddr], wmode, wdata);
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset values on every address of both ports.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b00, 3'd0, 8'h00, 3'(i), 3'(7 - i));
      check($sformatf("reset_addr%0d", i));
    end
    reset = 1'b0;

    // Load, then a disabled write must not disturb it.
    drive(1'b0, 2'b00, 3'd3, 8'hC3, 3'd3, 3'd5); check("load_pre");
    tick();                                      check("load_post");
    drive(1'b1, 2'b00, 3'd3, 8'hFF, 3'd3, 3'd5); check("noWE_pre");
    tick();                                      check("noWE_post");

    // Wrap around on inc/dec, then clear to zero (not the reset value).
    drive(1'b0, 2'b00, 3'd2, 8'hFF, 3'd2, 3'd5); tick(); check("wrap_load");
    drive(1'b0, 2'b01, 3'd2, 8'h33, 3'd2, 3'd5); check("inc_pre");  tick(); check("inc_post");
    drive(1'b0, 2'b10, 3'd2, 8'h33, 3'd2, 3'd5); check("dec_pre");  tick(); check("dec_post");
    drive(1'b0, 2'b11, 3'd2, 8'h33, 3'd2, 3'd5); check("clr_pre");  tick(); check("clr_post");
    drive(1'b0, 2'b10, 3'd2, 8'h33, 3'd2, 3'd5); tick(); check("dec_from_clear");

    // Both ports on the write address: u0 forwards, u1 shows the old value.
    drive(1'b0, 2'b00, 3'd4, 8'h11, 3'd4, 3'd4); check("bypass_pre");
    tick();                                      check("bypass_post");

    // Guards: reg 0 and an out-of-range address on the 6-entry instance.
    drive(1'b0, 2'b00, 3'd0, 8'hAA, 3'd0, 3'd3); check("zero_pre");
    tick();                                      check("zero_post");
    drive(1'b0, 2'b00, 3'd7, 8'h3C, 3'd7, 3'd6); check("oor_pre");
    tick();                                      check("oor_post");
    drive(1'b0, 2'b01, 3'd6, 8'h00, 3'd6, 3'd7); tick(); check("oor_inc");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b00, 3'd0, 8'h00, 3'(i), 3'(i));
      check($sformatf("sweep_addr%0d", i));
    end

    // Asynchronous reset between edges with a write pending.
    drive(1'b0, 2'b00, 3'd1, 8'h77, 3'd1, 3'd2); tick(); check("pre_rst_load");
    drive(1'b0, 2'b00, 3'd1, 8'h99, 3'd1, 3'd3);
    #2;
    reset = 1'b1;
    model_reset();
    check("async_rst_now");
    tick();
    check("rst_held_edge");
    reset = 1'b0;
    drive(1'b1, 2'b00, 3'd1, 8'h99, 3'd1, 3'd3); check("rst_release");
    drive(1'b0, 2'b00, 3'd1, 8'h42, 3'd1, 3'd3); tick(); check("first_write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
